// File: rtl/cram_arbiter_pkg.sv
// Shared types and constants for the CellularRAM arbiter/sequencer.
package cram_arbiter_pkg;

  localparam int ADDR_W    = 26;
  localparam int DATA_W    = 16;
  localparam int T_ACC_DEF = 8;
  localparam int T_REC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RECOV  = 2'd2
  } state_t;

  // Active-high byte enables {upper, lower} to the RAM's active-low {UB, LB}.
  function automatic logic [1:0] byte_lanes_n(input logic [1:0] be);
    return ~be;
  endfunction

endpackage

// File: rtl/cram_arbiter_if.sv
// One requester port of the CellularRAM arbiter: request, command and ack.
interface cram_arbiter_if;
  import cram_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        be;
  logic              ack;

  modport master (output req, output we, output addr, output wdata, output be, input ack);
  modport slave  (input req, input we, input addr, input wdata, input be, output ack);

endinterface

// File: rtl/cram_rr_arbiter.sv
// Two-way round-robin grant: on a tie the port that did not win last time wins.
module cram_rr_arbiter (
  input  logic       en,
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       next_last
);

  // One-hot grant and updated last-grant pointer.
  always_comb begin
    gnt       = 2'b00;
    next_last = last_grant;
    if (en) begin
      if (req0 && req1) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else if (req0) begin
        gnt = 2'b01;
      end else if (req1) begin
        gnt = 2'b10;
      end
      if (gnt[0]) begin
        next_last = 1'b0;
      end else if (gnt[1]) begin
        next_last = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cram_arbiter.sv
// Two-port arbiter and asynchronous single-word sequencer for CellularRAM.
// All RAM pins are registered; the pad tristate is built from DQ_out/DQ_oe.
module cram_arbiter
  import cram_arbiter_pkg::*;
#(
  parameter int T_ACC = T_ACC_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  cram_arbiter_if.slave     p0,
  cram_arbiter_if.slave     p1,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DQ_in,
  output logic [DATA_W-1:0] DQ_out,
  output logic              DQ_oe,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic              ADV,
  output logic              CLK,
  output logic              CRE,
  input  logic              WAIT
);

  localparam int CNT_MAX = (T_ACC > T_REC) ? T_ACC : T_REC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              cur_port;
  logic              we_r;
  logic [1:0]        gnt;
  logic              next_last;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_be;

  // Asynchronous mode only: no burst clock, no address-valid, no config access.
  assign ADV = 1'b0;
  assign CLK = 1'b0;
  assign CRE = 1'b0;

  cram_rr_arbiter u_rr (
    .en         (state == IDLE),
    .req0       (p0.req),
    .req1       (p1.req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .next_last  (next_last)
  );

  // Command of the port being granted this cycle.
  always_comb begin
    sel_we    = p0.we;
    sel_addr  = p0.addr;
    sel_wdata = p0.wdata;
    sel_be    = p0.be;
    if (gnt[1]) begin
      sel_we    = p1.we;
      sel_addr  = p1.addr;
      sel_wdata = p1.wdata;
      sel_be    = p1.be;
    end
  end

  // Access sequencer: grant, hold CE low for T_ACC cycles, then recover for T_REC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      we_r       <= 1'b0;
      A          <= '0;
      DQ_out     <= '0;
      rd_data    <= '0;
      DQ_oe      <= 1'b0;
      CE         <= 1'b1;
      OE         <= 1'b1;
      WE         <= 1'b1;
      UB         <= 1'b1;
      LB         <= 1'b1;
      p0.ack     <= 1'b0;
      p1.ack     <= 1'b0;
    end else begin
      p0.ack <= 1'b0;
      p1.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            cur_port   <= gnt[1];
            last_grant <= next_last;
            we_r       <= sel_we;
            A          <= sel_addr;
            DQ_out     <= sel_wdata;
            {UB, LB}   <= byte_lanes_n(sel_be);
            cnt        <= CNT_W'(T_ACC - 1);
            CE         <= 1'b0;
            OE         <= sel_we;
            WE         <= ~sel_we;
            DQ_oe      <= sel_we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= RECOV;
            cnt   <= CNT_W'(T_REC - 1);
            CE    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            if (!we_r) begin
              rd_data <= DQ_in;
            end
            if (cur_port) begin
              p1.ack <= 1'b1;
            end else begin
              p0.ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOV: begin
          // Write data is held on the bus for the first recovery cycle only.
          DQ_oe <= 1'b0;
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_arbiter.sv
// Bench for cram_arbiter: small RAM model, acknowledge scoreboard, pin timing checks.
module tb_cram_arbiter;
  import cram_arbiter_pkg::*;

  localparam int TA = 8;
  localparam int TR = 2;
  localparam int PERIOD = TA + TR + 1;

  typedef struct {
    bit          port;
    bit          wr;
    logic [15:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rd_data;
  logic [25:0] A;
  logic [15:0] dq_in;
  logic [15:0] DQ_out;
  logic        DQ_oe, CE, OE, WE, UB, LB, ADV, CLK, CRE;
  logic        wait_pin = 1'b0;

  logic [15:0] mem [0:255];
  sb_t         sb [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  cram_arbiter_if p0_if ();
  cram_arbiter_if p1_if ();

  cram_arbiter #(.T_ACC(TA), .T_REC(TR)) dut (
    .clk     (clk),
    .rst     (rst),
    .p0      (p0_if),
    .p1      (p1_if),
    .rd_data (rd_data),
    .A       (A),
    .DQ_in   (dq_in),
    .DQ_out  (DQ_out),
    .DQ_oe   (DQ_oe),
    .CE      (CE),
    .OE      (OE),
    .WE      (WE),
    .UB      (UB),
    .LB      (LB),
    .ADV     (ADV),
    .CLK     (CLK),
    .CRE     (CRE),
    .WAIT    (wait_pin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: read data presented while CE/OE are low, byte-lane writes while CE/WE are low.
  always @(negedge clk) dq_in = (!CE && !OE) ? mem[A[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!CE && !WE) begin
      if (!LB) mem[A[7:0]][7:0]  = DQ_out[7:0];
      if (!UB) mem[A[7:0]][15:8] = DQ_out[15:8];
    end
  end

  // Pin invariants and acknowledge scoreboard.
  always @(negedge clk) begin
    sb_t e;
    chk("pins_const", {61'd0, ADV, CLK, CRE}, 64'd0);
    chk("we_oe_excl", {63'd0, (!WE && !OE)}, 64'd0);
    if (p0_if.ack || p1_if.ack) begin
      chk("ack_both", {63'd0, p0_if.ack && p1_if.ack}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexp_ack", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_port", {63'd0, p1_if.ack}, {63'd0, e.port});
        if (!e.wr) chk("sb_rdata", {48'd0, rd_data}, {48'd0, e.data});
      end
    end
  end

  task automatic drive(input bit port, input bit v, input bit wr, input logic [25:0] a,
                       input logic [15:0] wd, input logic [1:0] be);
    if (!port) begin
      p0_if.req = v; p0_if.we = wr; p0_if.addr = a; p0_if.wdata = wd; p0_if.be = be;
    end else begin
      p1_if.req = v; p1_if.we = wr; p1_if.addr = a; p1_if.wdata = wd; p1_if.be = be;
    end
  endtask

  // Single transaction with pin-timing measurement over one full period.
  task automatic do_txn(input string tag, input bit port, input bit wr, input logic [25:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input logic [15:0] rexp);
    int ce_lo = 0, we_lo = 0, oe_lo = 0, dq_hi = 0, a_ok = 0, lat = -1, t0;
    logic ub, lb;
    sb.push_back('{port, wr, rexp});
    drive(port, 1'b1, wr, addr, wd, be);
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    ub = UB;
    lb = LB;
    for (int k = 0; k < PERIOD + 1; k++) begin
      if (!CE) ce_lo++;
      if (!CE && A == addr) a_ok++;
      if (!WE) we_lo++;
      if (!OE) oe_lo++;
      if (DQ_oe) dq_hi++;
      if ((port ? p1_if.ack : p0_if.ack) && lat < 0) begin
        lat = cyc - t0;
        drive(port, 1'b0, wr, addr, wd, be);
      end
      @(negedge clk);
    end
    drive(port, 1'b0, wr, addr, wd, be);
    chk({tag, "_ce_low"}, ce_lo, TA);
    chk({tag, "_addr"}, a_ok, TA);
    chk({tag, "_we_low"}, we_lo, wr ? TA : 0);
    chk({tag, "_oe_low"}, oe_lo, wr ? 0 : TA);
    chk({tag, "_dq_oe"}, dq_hi, wr ? TA + 1 : 0);
    chk({tag, "_ack_lat"}, lat, TA);
    chk({tag, "_ub_lb"}, {62'd0, ub, lb}, {62'd0, ~be});
  endtask

  // Requests held from reset; acks counted, spacing and CE recovery gaps checked.
  task automatic stream(input string tag, input bit both, input int n);
    int acks = 0, last = -1, hi_run = 0;
    bit seen_lo = 0;
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 26'h40, 16'h0, 2'b11);
    if (both) drive(1'b1, 1'b1, 1'b0, 26'h41, 16'h0, 2'b11);
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (both && (i % 2 == 1)) sb.push_back('{1'b1, 1'b0, 16'h2222});
      else                      sb.push_back('{1'b0, 1'b0, 16'h1111});
    end
    rst = 1'b0;
    for (int k = 0; k < 200 && acks < n; k++) begin
      @(negedge clk);
      if (!CE) begin
        if (seen_lo && hi_run > 0) chk({tag, "_ce_gap"}, hi_run, TR + 1);
        seen_lo = 1;
        hi_run = 0;
      end else begin
        hi_run++;
      end
      if (p0_if.ack || p1_if.ack) begin
        if (last >= 0) chk({tag, "_ack_gap"}, cyc - last, PERIOD);
        last = cyc;
        acks++;
        if (acks == n) begin
          drive(1'b0, 1'b0, 1'b0, 26'h40, 16'h0, 2'b11);
          drive(1'b1, 1'b0, 1'b0, 26'h41, 16'h0, 2'b11);
        end
      end
    end
    chk({tag, "_acks"}, acks, n);
    drive(1'b0, 1'b0, 1'b0, 26'h40, 16'h0, 2'b11);
    drive(1'b1, 1'b0, 1'b0, 26'h41, 16'h0, 2'b11);
    repeat (PERIOD + 1) @(negedge clk);
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h23] = 16'hBEEF;
    mem[8'hFF] = 16'h1234;
    mem[8'h40] = 16'h1111;
    mem[8'h41] = 16'h2222;
    mem[8'h70] = 16'h7777;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 26'h0, 16'h0, 2'b00);
    repeat (3) @(negedge clk);

    chk("rst_ctl", {59'd0, CE, OE, WE, UB, LB}, {59'd0, 5'b11111});
    chk("rst_dq_oe", {63'd0, DQ_oe}, 64'd0);
    chk("rst_addr", {38'd0, A}, 64'd0);
    chk("rst_data", {32'd0, DQ_out, rd_data}, 64'd0);
    chk("rst_ack", {62'd0, p0_if.ack, p1_if.ack}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_txn("rd1", 1'b1, 1'b0, 26'h0000123, 16'h0000, 2'b11, 16'hBEEF);
    chk("rd1_rdata", {48'd0, rd_data}, {48'd0, 16'hBEEF});

    do_txn("wr0", 1'b0, 1'b1, 26'h3FFFFFF, 16'hA55A, 2'b01, 16'h0000);
    chk("wr0_mem", {48'd0, mem[8'hFF]}, {48'd0, 16'h125A});
    chk("wr0_rd_hold", {48'd0, rd_data}, {48'd0, 16'hBEEF});

    stream("rr", 1'b1, 6);
    stream("b2b", 1'b0, 3);

    // Abort a write at cycle 4 of its access.
    drive(1'b0, 1'b1, 1'b1, 26'h60, 16'hCAFE, 2'b11);
    @(posedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctl", {61'd0, CE, WE, OE}, {61'd0, 3'b111});
    chk("abort_dq_oe", {63'd0, DQ_oe}, 64'd0);
    drive(1'b0, 1'b0, 1'b1, 26'h60, 16'hCAFE, 2'b11);
    acks = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (PERIOD + 1) begin
      @(negedge clk);
      if (p0_if.ack || p1_if.ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    do_txn("fresh", 1'b0, 1'b0, 26'h70, 16'h0000, 2'b11, 16'h7777);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
